seg_word_shifter: RTL and testbench
===================================

# seg_word_shifter

Parallel-to-serial shifter that drives the board's daisy-chained seven-segment shift registers. It takes the 32-bit display word chosen by the upstream 4:1 display-data selector and shifts it out MSB-first on a serial data/clock pair. When all bits are out, it issues a latch pulse and reports completion. One transfer runs per accepted `start`; `start` requests during a transfer are ignored.

## Interface
- `WIDTH`, 32: number of bits per transfer (≥1); equals the selector output width.
- `DIV`, 2: clk cycles per serial-clock half-period (≥1).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `din`  in  WIDTH  word to send; captured on the edge that accepts `start`.
- `s_clk`  out  1  serial shift clock to the external registers.
- `s_dat`  out  1  serial data, MSB first.
- `s_lat`  out  1  latch/strobe, high for DIV cycles after the last bit.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered.
- Reset values: `s_clk`=0, `s_dat`=0, `s_lat`=0, `busy`=0, `done`=0. Reset also clears the state to IDLE, the shift register, the bit counter and the phase counter.
- FSM states: IDLE, LOW, HIGH, LATCH.
- **IDLE**
  - `start`=1: load `din` into the shift register and set bit counter=WIDTH.
  - Next state LOW; `busy`←1; `s_dat`←`din[WIDTH-1]`.
  - `start`=0: remain in IDLE.
- **LOW**
  - `s_clk`=0; `s_dat` shows the current MSB of the shift register.
  - Hold DIV cycles, then go to HIGH.
- **HIGH**
  - `s_clk`=1 for DIV cycles; `s_dat` is held stable.
  - On leaving HIGH: shift left by 1 (zero fill) and decrement the bit counter.
  - Counter still nonzero: go to LOW, with `s_dat` updated in the same edge.
  - Counter reaches 0: go to LATCH with `s_dat`←0.
- **LATCH**
  - `s_lat`=1 and `s_clk`=0 for DIV cycles.
  - Then go to IDLE with `s_lat`←0, `busy`←0, `done`←1.
- `done` is high only in the first IDLE cycle after LATCH.
- A `start` in that same cycle is accepted, giving back-to-back transfers with no gap.
- `start` in LOW/HIGH/LATCH has no effect and is not queued.
- `din` changes after capture have no effect on the transfer in progress.
- The phase counter is ceil(log2(DIV+1)) bits and resets to 0 on every state change.
- The bit counter is ceil(log2(WIDTH+1)) bits.
- `rst` mid-transfer:
  - All outputs go to reset values after that edge.
  - No `done` and no `s_lat` are produced for the aborted word.
  - A `start` coinciding with `rst` is dropped.

## Timing
- Let E0 be the edge that accepts `start`. Ek is the k-th following edge.
- Bit i (i=0 is the MSB) appears on `s_dat` after E(2·i·DIV).
- `s_clk` rises after E((2i+1)·DIV) and falls after E((2i+2)·DIV).
- Setup and hold at the `s_clk` rising edge are each DIV cycles.
- `s_lat` is high from after E(2·WIDTH·DIV) until after E((2·WIDTH+1)·DIV).
- `done`=1 and `busy`=0 after E((2·WIDTH+1)·DIV), for exactly one cycle.
- Total latency from accepting `start` to `done` is (2·WIDTH+1)·DIV cycles.
- `s_clk` and `s_lat` are never high simultaneously.
- `s_clk` is low whenever `busy`=0.

## Test plan
- Reset/idle: hold `rst` 3 cycles, then idle 10 cycles. All outputs stay 0 and `s_clk` never toggles.
- Single word (WIDTH=32, DIV=2): `din`=0xA5C3_0F81 with a one-cycle `start`.
  - Exactly 32 `s_clk` rising edges.
  - Bits sampled at those edges reconstruct 0xA5C30F81.
  - `s_lat` is high after E128 through E130.
  - `done` pulses after E130; `busy` is high for E0..E130.
- Busy-ignore: pulse `start` with `din`=0xFFFF_FFFF at E10 during a transfer of 0x0000_0001.
  - Only 0x00000001 is shifted.
  - One `done` pulse.
  - No second transfer.
- Back-to-back: hold `start`=1 continuously with `din` toggling 0x1234_5678 / 0x8765_4321.
  - Second transfer begins on the `done` cycle; `s_dat` is 0 there (MSB of 0x12345678 is 0... next word's MSB=1 visible after that edge).
  - Both words are received correctly.
- Reset mid-op: assert `rst` at E40 of a transfer.
  - All outputs are 0 after E40.
  - No `s_lat` and no `done` occur.
  - A fresh transfer of 0x0000_00FF afterwards completes correctly.
- DIV=1, WIDTH=4: `din`=4'b1011.
  - `s_clk` has period 2 clk.
  - Sampled bits are 1,0,1,1.
  - `done` pulses after E9.

Source files
------------

// File: rtl/seg_word_shifter_if.sv
// Handshake and serial-pin bundle for the seven-segment word shifter.
// The master drives start/din; the slave drives the serial outputs and status.
interface seg_word_shifter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             s_clk;
    logic             s_dat;
    logic             s_lat;
    logic             busy;
    logic             done;

    modport master (
        output start, din,
        input  s_clk, s_dat, s_lat, busy, done
    );

    modport slave (
        input  start, din,
        output s_clk, s_dat, s_lat, busy, done
    );
endinterface

// File: rtl/seg_word_shifter.sv
// Parallel-to-serial shifter for the daisy-chained seven-segment registers.
// Shifts WIDTH bits MSB-first, then strobes the latch and pulses done.
module seg_word_shifter #(
    parameter int WIDTH = 32,
    parameter int DIV   = 2
) (
    input  logic               clk,
    input  logic               rst,
    seg_word_shifter_if.slave  bus
);
    localparam int PW = $clog2(DIV + 1);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOW   = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    logic [1:0]       r_state;
    logic [PW-1:0]    r_phase;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic             r_sclk;
    logic             r_sdat;
    logic             r_slat;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shift;
    logic             w_ph_end;

    assign w_shift  = r_sr << 1;
    assign w_ph_end = (r_phase == PH_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_sclk  <= 1'b0;
            r_sdat  <= 1'b0;
            r_slat  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sr    <= bus.din;
                        r_cnt   <= CW'(WIDTH);
                        r_phase <= '0;
                        r_state <= S_LOW;
                        r_busy  <= 1'b1;
                        r_sdat  <= bus.din[WIDTH-1];
                    end
                end
                S_LOW: begin
                    if (w_ph_end) begin
                        r_state <= S_HIGH;
                        r_phase <= '0;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                S_HIGH: begin
                    if (w_ph_end) begin
                        r_sclk  <= 1'b0;
                        r_sr    <= w_shift;
                        r_cnt   <= r_cnt - CW'(1);
                        r_phase <= '0;
                        // last bit just clocked out: data idles low during latch
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_LATCH;
                            r_sdat  <= 1'b0;
                            r_slat  <= 1'b1;
                        end else begin
                            r_state <= S_LOW;
                            r_sdat  <= w_shift[WIDTH-1];
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                S_LATCH: begin
                    if (w_ph_end) begin
                        r_state <= S_IDLE;
                        r_phase <= '0;
                        r_slat  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_phase <= '0;
                end
            endcase
        end
    end

    assign bus.s_clk = r_sclk;
    assign bus.s_dat = r_sdat;
    assign bus.s_lat = r_slat;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_seg_word_shifter.sv
// Directed bench for seg_word_shifter: 32-bit/DIV=2 and 4-bit/DIV=1 instances.
// Outputs are sampled on the falling clock edge, inputs driven there too.
module tb_seg_word_shifter;
    logic clk;
    logic rst;

    seg_word_shifter_if #(.WIDTH(32)) b32 ();
    seg_word_shifter_if #(.WIDTH(4))  b4 ();

    seg_word_shifter #(.WIDTH(32), .DIV(2)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    seg_word_shifter #(.WIDTH(4), .DIV(1)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_err;

    typedef struct {
        logic [31:0] word;
        int          rises;
        int          lat_first;
        int          lat_cnt;
        int          done_k;
        int          viol;
    } res_t;

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp_word;
        int          exp_rises;
        int          exp_lat_first;
        int          exp_lat_cnt;
        int          exp_done_k;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at the falling edge after E0 (k=0); returns at the done cycle.
    task automatic watch(input int pulse_k, input logic [31:0] pdin,
                         output res_t r);
        logic prev;
        int   k;
        r.word      = '0;
        r.rises     = 0;
        r.lat_first = -1;
        r.lat_cnt   = 0;
        r.done_k    = -1;
        r.viol      = 0;
        prev        = 1'b0;
        for (k = 0; k < 400; k++) begin
            if (k == pulse_k - 1) begin
                b32.start = 1'b1;
                b32.din   = pdin;
            end
            if (k == pulse_k) b32.start = 1'b0;
            if (b32.s_clk && !prev) begin
                r.word = {r.word[30:0], b32.s_dat};
                r.rises++;
            end
            if (b32.s_lat) begin
                if (r.lat_first < 0) r.lat_first = k;
                r.lat_cnt++;
            end
            if (b32.s_clk && b32.s_lat) r.viol++;
            if (!b32.busy && b32.s_clk) r.viol++;
            if (b32.done) begin
                if (b32.busy) r.viol++;
                r.done_k = k;
                break;
            end
            if (!b32.busy) r.viol++;
            prev = b32.s_clk;
            @(negedge clk);
        end
    endtask

    task automatic check_res(input string tag, input res_t r,
                             input vec_t v);
        chk({tag, ".word"},  r.word, v.exp_word);
        chk({tag, ".rises"}, r.rises, v.exp_rises);
        chk({tag, ".lat0"},  r.lat_first, v.exp_lat_first);
        chk({tag, ".latn"},  r.lat_cnt, v.exp_lat_cnt);
        chk({tag, ".done"},  r.done_k, v.exp_done_k);
        chk({tag, ".viol"},  r.viol, 0);
    endtask

    vec_t vecs [5];
    res_t r;
    res_t r2;

    initial begin
        int viol;
        int ev;
        int rise_k [4];
        int nr;
        logic [3:0] w4;
        logic p4;
        int dk;

        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        b32.start = 1'b0;
        b32.din   = '0;
        b4.start  = 1'b0;
        b4.din    = '0;

        vecs[0] = '{32'hA5C3_0F81, 32'hA5C3_0F81, 32, 128, 2, 130};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 32, 128, 2, 130};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 128, 2, 130};
        vecs[3] = '{32'h8000_0001, 32'h8000_0001, 32, 128, 2, 130};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 32, 128, 2, 130};

        // reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b32.s_clk || b32.s_dat || b32.s_lat || b32.busy || b32.done)
                viol++;
            if (b4.s_clk || b4.s_dat || b4.s_lat || b4.busy || b4.done)
                viol++;
        end
        chk("reset_idle", viol, 0);

        // table-driven single transfers
        for (int i = 0; i < 5; i++) begin
            b32.start = 1'b1;
            b32.din   = vecs[i].din;
            @(negedge clk);
            b32.start = 1'b0;
            b32.din   = ~vecs[i].din;
            watch(-1, '0, r);
            check_res($sformatf("vec%0d", i), r, vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d.busy_off", i), b32.busy, 1'b0);
        end

        // start during a transfer is ignored
        b32.start = 1'b1;
        b32.din   = 32'h0000_0001;
        @(negedge clk);
        b32.start = 1'b0;
        watch(10, 32'hFFFF_FFFF, r);
        check_res("ign", r, '{32'h1, 32'h1, 32, 128, 2, 130});
        ev = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b32.busy || b32.done || b32.s_clk) ev++;
        end
        chk("ign.no_second", ev, 0);

        // back-to-back with start held
        b32.start = 1'b1;
        b32.din   = 32'h1234_5678;
        @(negedge clk);
        b32.din   = 32'h8765_4321;
        watch(-1, '0, r);
        check_res("b2b0", r, vecs[4]);
        chk("b2b.sdat_done", b32.s_dat, 1'b0);
        @(negedge clk);
        b32.start = 1'b0;
        chk("b2b.sdat_msb", b32.s_dat, 1'b1);
        chk("b2b.busy", b32.busy, 1'b1);
        watch(-1, '0, r2);
        check_res("b2b1", r2, '{32'h8765_4321, 32'h8765_4321, 32, 128, 2, 130});
        @(negedge clk);

        // reset mid-transfer
        b32.start = 1'b1;
        b32.din   = 32'hFFFF_FFFF;
        @(negedge clk);
        b32.start = 1'b0;
        for (int k = 1; k < 40; k++) @(negedge clk);
        rst = 1'b1;
        b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        chk("rst.outs", {b32.s_clk, b32.s_dat, b32.s_lat, b32.busy, b32.done}, 0);
        rst = 1'b0;
        ev = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (b32.s_lat || b32.done || b32.busy) ev++;
        end
        chk("rst.no_tail", ev, 0);
        b32.start = 1'b1;
        b32.din   = 32'h0000_00FF;
        @(negedge clk);
        b32.start = 1'b0;
        watch(-1, '0, r);
        check_res("post_rst", r, '{32'hFF, 32'hFF, 32, 128, 2, 130});
        @(negedge clk);

        // WIDTH=4, DIV=1
        b4.start = 1'b1;
        b4.din   = 4'b1011;
        @(negedge clk);
        b4.start = 1'b0;
        b4.din   = 4'b0000;
        nr = 0;
        w4 = '0;
        p4 = 1'b0;
        dk = -1;
        viol = 0;
        for (int k = 0; k < 40; k++) begin
            if (b4.s_clk && !p4) begin
                if (nr < 4) rise_k[nr] = k;
                w4 = {w4[2:0], b4.s_dat};
                nr++;
            end
            if (b4.s_clk && b4.s_lat) viol++;
            if (b4.done) begin
                dk = k;
                break;
            end
            p4 = b4.s_clk;
            @(negedge clk);
        end
        chk("w4.rises", nr, 4);
        chk("w4.bits", w4, 4'b1011);
        chk("w4.done", dk, 9);
        chk("w4.rise0", rise_k[0], 1);
        chk("w4.period", rise_k[3] - rise_k[2], 2);
        chk("w4.viol", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
